// File: rtl/cvxif_offload_responder.sv
// rtl/cvxif_offload_responder.sv - CVXIF coprocessor responder: in-order queue plus custom-0 execute unit
module cvxif_offload_responder #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4,
  parameter int MUL_LATENCY   = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  input  logic [XLEN-1:0]          issue_rs1_i,
  input  logic [XLEN-1:0]          issue_rs2_i,
  output logic                     result_valid_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
  output logic [XLEN-1:0]          result_data_o,
  output logic                     result_we_o,
  output logic                     result_ex_valid_o,
  output logic [XLEN-1:0]          result_ex_cause_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(MUL_LATENCY + 1);

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_CADD     = 3'b000;
  localparam logic [2:0] F3_CMUL     = 3'b001;
  localparam logic [2:0] F3_CNOP     = 3'b010;

  typedef enum logic {IDLE, BUSY} state_t;

  // Input queue storage and bookkeeping
  logic [31:0]              fifo_instr [DEPTH];
  logic [TRANS_ID_BITS-1:0] fifo_id    [DEPTH];
  logic [XLEN-1:0]          fifo_rs1   [DEPTH];
  logic [XLEN-1:0]          fifo_rs2   [DEPTH];
  logic [PW-1:0]            wptr;
  logic [PW-1:0]            rptr;
  logic [CW-1:0]            count;
  logic                     push;
  logic                     pop;
  logic                     empty;

  // Head-of-queue view and its decode
  logic [31:0]              head_instr;
  logic [TRANS_ID_BITS-1:0] head_id;
  logic [XLEN-1:0]          head_rs1;
  logic [XLEN-1:0]          head_rs2;
  logic [6:0]               head_opcode;
  logic [2:0]               head_funct3;
  logic [4:0]               head_rd;
  logic                     unused_instr_bits;
  logic [XLEN-1:0]          dec_data;
  logic                     dec_we;
  logic                     dec_ex;
  logic [LW-1:0]            dec_lat;

  // Execution unit state and the op it is holding
  state_t                   state;
  state_t                   state_n;
  logic [LW-1:0]            cnt;
  logic [LW-1:0]            cnt_n;
  logic [TRANS_ID_BITS-1:0] exec_id;
  logic [XLEN-1:0]          exec_data;
  logic                     exec_we;
  logic                     exec_ex;

  // Values written to the result port when the unit enters its completing cycle
  logic                     load_out;
  logic [TRANS_ID_BITS-1:0] out_id;
  logic [XLEN-1:0]          out_data;
  logic                     out_we;
  logic                     out_ex;

  // A pop while full never opens a slot in the same cycle, so ready ignores pop
  assign empty         = (count == '0);
  assign issue_ready_o = (count < CW'(DEPTH)) && !flush_i;
  assign push          = issue_valid_i && issue_ready_o;

  assign head_instr  = fifo_instr[rptr];
  assign head_id     = fifo_id[rptr];
  assign head_rs1    = fifo_rs1[rptr];
  assign head_rs2    = fifo_rs2[rptr];
  assign head_opcode = head_instr[6:0];
  assign head_rd     = head_instr[11:7];
  assign head_funct3 = head_instr[14:12];
  assign unused_instr_bits = ^head_instr[31:15];

  // Queue storage; payload needs no reset because count gates its use
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr[wptr] <= issue_instr_i;
      fifo_id[wptr]    <= issue_trans_id_i;
      fifo_rs1[wptr]   <= issue_rs1_i;
      fifo_rs2[wptr]   <= issue_rs2_i;
    end
  end

  // Queue pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Decode the head instruction into its result, write enable, exception and latency
  always_comb begin
    dec_data = '0;
    dec_we   = 1'b0;
    dec_ex   = 1'b0;
    dec_lat  = LW'(1);
    if (head_opcode == OPC_CUSTOM0) begin
      case (head_funct3)
        F3_CADD: begin
          dec_data = head_rs1 + head_rs2;
          dec_we   = (head_rd != 5'd0);
        end
        F3_CMUL: begin
          dec_data = head_rs1 * head_rs2;
          dec_we   = (head_rd != 5'd0);
          dec_lat  = LW'(MUL_LATENCY);
        end
        F3_CNOP: begin
          dec_data = '0;
        end
        default: begin
          dec_ex = 1'b1;
        end
      endcase
    end else begin
      dec_ex = 1'b1;
    end
  end

  // Execution unit state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: pop when idle or on the completing busy cycle; flush wins
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == LW'(1)) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (pop) begin
      state_n = BUSY;
      cnt_n   = dec_lat;
    end
    if (flush_i) begin
      state_n = IDLE;
      cnt_n   = '0;
      pop     = 1'b0;
    end
  end

  // Latch the popped op so multi-cycle ops keep their result while counting down
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exec_id   <= '0;
      exec_data <= '0;
      exec_we   <= 1'b0;
      exec_ex   <= 1'b0;
    end else if (pop) begin
      exec_id   <= head_id;
      exec_data <= dec_data;
      exec_we   <= dec_we;
      exec_ex   <= dec_ex;
    end
  end

  // Result source: a single-cycle op completes straight from the head, others from the held op
  always_comb begin
    load_out = !flush_i && (state_n == BUSY) && (cnt_n == LW'(1));
    out_id   = exec_id;
    out_data = exec_data;
    out_we   = exec_we;
    out_ex   = exec_ex;
    if (pop) begin
      out_id   = head_id;
      out_data = dec_data;
      out_we   = dec_we;
      out_ex   = dec_ex;
    end
  end

  // Result port registers; payload holds between results, valid is a one-cycle pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_o    <= 1'b0;
      result_trans_id_o <= '0;
      result_data_o     <= '0;
      result_we_o       <= 1'b0;
      result_ex_valid_o <= 1'b0;
      result_ex_cause_o <= '0;
    end else begin
      result_valid_o <= load_out;
      if (load_out) begin
        result_trans_id_o <= out_id;
        result_data_o     <= out_data;
        result_we_o       <= out_we;
        result_ex_valid_o <= out_ex;
        result_ex_cause_o <= out_ex ? XLEN'(2) : '0;
      end
    end
  end

endmodule
